// File: rtl/secure_bank_arbiter.sv
// secure_bank_arbiter: two-requester round-robin arbiter in front of a
// password-checked, parity-routed pair of storage banks.
// Each request is latched, its password checked, and its nibble written to
// the odd (left) or even (right) bank. Repeated bad passwords cause a lockout.
module secure_bank_arbiter #(
    parameter int DEPTH       = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [3:0]                 secret_pass,
    input  logic [1:0]                 req,
    input  logic [7:0]                 pass_data,
    input  logic [7:0]                 din,
    input  logic                       clear_banks,
    output logic [1:0]                 grant,
    output logic [1:0]                 done,
    output logic [1:0]                 reject,
    output logic                       locked,
    output logic                       en_left,
    output logic                       en_right,
    output logic [$clog2(DEPTH)-1:0]   waddr,
    output logic [3:0]                 dout,
    output logic [$clog2(DEPTH):0]     left_count,
    output logic [$clog2(DEPTH):0]     right_count,
    output logic                       left_full,
    output logic                       right_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [FW-1:0] FAIL_LIM  = FW'(MAX_FAIL);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_FAIL,
        S_LOCK
    } state_t;

    // transaction state
    state_t        state_q, state_d;
    logic [1:0]    win_q, win_d;        // one-hot owner of the current transaction
    logic [3:0]    pass_q, pass_d;      // latched password
    logic [3:0]    data_q, data_d;      // latched data nibble
    logic          bad_q, bad_d;        // refusal was a password mismatch
    logic          last_b_q, last_b_d;  // last grant went to B
    logic [FW-1:0] fail_q, fail_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;

    // registered outputs
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    reject_q, reject_d;
    logic          locked_q, locked_d;
    logic          en_left_q, en_left_d;
    logic          en_right_q, en_right_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [3:0]    dout_q, dout_d;

    logic          pick_b;
    logic          tgt_full;
    logic          pass_ok;
    logic          xfer;

    // next-state, bank bookkeeping and next-output decode
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        pass_d   = pass_q;
        data_d   = data_q;
        bad_d    = bad_q;
        last_b_d = last_b_q;
        fail_d   = fail_q;
        lock_d   = lock_q;
        lcnt_d   = lcnt_q;
        rcnt_d   = rcnt_q;
        pick_b   = 1'b0;
        tgt_full = data_q[0] ? (lcnt_q == DEPTH_C) : (rcnt_q == DEPTH_C);
        pass_ok  = (pass_q == secret_pass);

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    // B wins alone, or on a tie when A was served last
                    pick_b   = req[1] & (~req[0] | ~last_b_q);
                    state_d  = S_CHECK;
                    win_d    = pick_b ? 2'b10 : 2'b01;
                    last_b_d = pick_b;
                    pass_d   = pick_b ? pass_data[7:4] : pass_data[3:0];
                    data_d   = pick_b ? din[7:4] : din[3:0];
                end
            end
            S_CHECK: begin
                bad_d   = ~pass_ok;
                state_d = (pass_ok && !tgt_full) ? S_WRITE : S_FAIL;
            end
            S_WRITE: begin
                state_d = S_IDLE;
                fail_d  = '0;
                if (data_q[0]) begin
                    if (lcnt_q != DEPTH_C) lcnt_d = lcnt_q + 1'b1;
                end else begin
                    if (rcnt_q != DEPTH_C) rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_FAIL: begin
                state_d = S_IDLE;
                // a full-bank refusal does not count toward lockout
                if (bad_q) begin
                    fail_d = fail_q + 1'b1;
                    if (fail_d == FAIL_LIM) begin
                        state_d = S_LOCK;
                        lock_d  = '0;
                    end
                end
            end
            S_LOCK: begin
                if (lock_q == LOCK_LAST) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a clear coinciding with a write leaves just that write in its bank
        if (clear_banks) begin
            lcnt_d = '0;
            rcnt_d = '0;
            if (state_q == S_WRITE) begin
                if (data_q[0]) lcnt_d = CW'(1);
                else           rcnt_d = CW'(1);
            end
        end

        xfer       = (state_d == S_CHECK) || (state_d == S_WRITE) || (state_d == S_FAIL);
        grant_d    = xfer ? win_d : 2'b00;
        done_d     = (state_d == S_WRITE) ? win_d : 2'b00;
        reject_d   = (state_d == S_FAIL) ? win_d : 2'b00;
        locked_d   = (state_d == S_LOCK);
        en_left_d  = (state_d == S_WRITE) &&  data_d[0];
        en_right_d = (state_d == S_WRITE) && !data_d[0];
        waddr_d    = '0;
        if (state_d == S_WRITE) waddr_d = data_d[0] ? lcnt_d[AW-1:0] : rcnt_d[AW-1:0];
        dout_d     = (state_d == S_WRITE) ? data_d : 4'h0;
    end

    // single register bank for the FSM, its datapath and its outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            win_q      <= 2'b00;
            pass_q     <= 4'h0;
            data_q     <= 4'h0;
            bad_q      <= 1'b0;
            last_b_q   <= 1'b1;
            fail_q     <= '0;
            lock_q     <= '0;
            lcnt_q     <= '0;
            rcnt_q     <= '0;
            grant_q    <= 2'b00;
            done_q     <= 2'b00;
            reject_q   <= 2'b00;
            locked_q   <= 1'b0;
            en_left_q  <= 1'b0;
            en_right_q <= 1'b0;
            waddr_q    <= '0;
            dout_q     <= 4'h0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            pass_q     <= pass_d;
            data_q     <= data_d;
            bad_q      <= bad_d;
            last_b_q   <= last_b_d;
            fail_q     <= fail_d;
            lock_q     <= lock_d;
            lcnt_q     <= lcnt_d;
            rcnt_q     <= rcnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            reject_q   <= reject_d;
            locked_q   <= locked_d;
            en_left_q  <= en_left_d;
            en_right_q <= en_right_d;
            waddr_q    <= waddr_d;
            dout_q     <= dout_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign reject      = reject_q;
    assign locked      = locked_q;
    assign en_left     = en_left_q;
    assign en_right    = en_right_q;
    assign waddr       = waddr_q;
    assign dout        = dout_q;
    assign left_count  = lcnt_q;
    assign right_count = rcnt_q;
    assign left_full   = (lcnt_q == DEPTH_C);
    assign right_full  = (rcnt_q == DEPTH_C);

endmodule

// File: tb/tb_secure_bank_arbiter.sv
// Directed bench for secure_bank_arbiter (DEPTH=4, MAX_FAIL=3, LOCK_CYCLES=8,
// secret 0xA). Inputs change 1ns after a rising edge; outputs are checked there.
module tb_secure_bank_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] secret_pass = 4'hA;
    logic [1:0] req = 2'b00;
    logic [7:0] pass_data = 8'h00;
    logic [7:0] din = 8'h00;
    logic       clear_banks = 1'b0;
    logic [1:0] grant, done, reject;
    logic       locked, en_left, en_right;
    logic [1:0] waddr;
    logic [3:0] dout;
    logic [2:0] left_count, right_count;
    logic       left_full, right_full;

    int total = 0;
    int bad   = 0;

    secure_bank_arbiter #(.DEPTH(4), .MAX_FAIL(3), .LOCK_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .secret_pass(secret_pass), .req(req),
        .pass_data(pass_data), .din(din), .clear_banks(clear_banks),
        .grant(grant), .done(done), .reject(reject), .locked(locked),
        .en_left(en_left), .en_right(en_right), .waddr(waddr), .dout(dout),
        .left_count(left_count), .right_count(right_count),
        .left_full(left_full), .right_full(right_full)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; req = 2'b00; clear_banks = 1'b0; pass_data = 8'h00; din = 8'h00;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        tick; tick;
        total++;
        if ({grant, done, reject, locked, en_left, en_right, waddr, dout,
             left_count, right_count, left_full, right_full} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {grant, done, reject, locked, en_left,
                     en_right, waddr, dout, left_count, right_count, left_full, right_full});
        end
        reset = 1'b0;
        tick;
        total++;
        if ({grant, locked, left_count, right_count} !== 9'd0) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=0", {grant, locked, left_count, right_count});
        end
    endtask

    task automatic test_single_write;
        do_reset;
        req = 2'b01; pass_data = 8'h0A; din = 8'h04;
        tick;
        total++;
        if ({grant, done, en_left, en_right} !== 6'b01_00_00) begin
            bad++;
            $display("FAIL single_c1 got=%b exp=010000", {grant, done, en_left, en_right});
        end
        // late input changes must not disturb the latched transaction
        req = 2'b00; pass_data = 8'h55; din = 8'hFF;
        tick;
        total++;
        if ({grant, done, en_left, en_right, waddr, dout} !== {2'b01, 2'b01, 1'b0, 1'b1, 2'd0, 4'h4}) begin
            bad++;
            $display("FAIL single_c2 got=%b exp=%b", {grant, done, en_left, en_right, waddr, dout},
                     {2'b01, 2'b01, 1'b0, 1'b1, 2'd0, 4'h4});
        end
        tick;
        total++;
        if ({right_count, left_count, grant, done} !== {3'd1, 3'd0, 2'b00, 2'b00}) begin
            bad++;
            $display("FAIL single_c3 rc=%0d lc=%0d grant=%b done=%b exp rc=1 lc=0 grant=00 done=00",
                     right_count, left_count, grant, done);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        do_reset;
        req = 2'b11; pass_data = 8'hAA; din = 8'h32;  // A even -> right, B odd -> left
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
            tick;
            total++;
            if (grant !== exp) begin
                bad++;
                $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant, exp);
            end
            tick;
            total++;
            if ({grant, done, en_left, en_right, waddr, dout} !==
                {exp, exp, exp[1], exp[0], 2'(k / 2), (exp[1] ? 4'h3 : 4'h2)}) begin
                bad++;
                $display("FAIL rr_write k=%0d got=%b exp=%b", k,
                         {grant, done, en_left, en_right, waddr, dout},
                         {exp, exp, exp[1], exp[0], 2'(k / 2), (exp[1] ? 4'h3 : 4'h2)});
            end
            if (k == 3) req = 2'b00;
            tick;
            total++;
            if ({grant, done} !== 4'b0) begin
                bad++;
                $display("FAIL rr_idle k=%0d grant=%b done=%b exp 00 00", k, grant, done);
            end
        end
        total++;
        if ({left_count, right_count} !== {3'd2, 3'd2}) begin
            bad++;
            $display("FAIL rr_counts lc=%0d rc=%0d exp 2 2", left_count, right_count);
        end
    endtask

    task automatic test_lockout;
        do_reset;
        pass_data = 8'hA3; din = 8'h50;  // A wrong, B correct with odd data 5
        for (int k = 0; k < 3; k++) begin
            req = 2'b01;
            tick;
            total++;
            if (grant !== 2'b01) begin
                bad++;
                $display("FAIL lock_grant k=%0d got=%b exp=01", k, grant);
            end
            tick;
            total++;
            if ({reject, done, en_left, en_right, locked} !== 7'b01_00_000) begin
                bad++;
                $display("FAIL lock_reject k=%0d got=%b exp=0100000", k,
                         {reject, done, en_left, en_right, locked});
            end
            if (k < 2) begin
                req = 2'b00;
                tick;
                total++;
                if (locked !== 1'b0) begin
                    bad++;
                    $display("FAIL lock_early k=%0d locked=%b exp=0", k, locked);
                end
            end
        end
        req = 2'b10;
        for (int i = 0; i < 8; i++) begin
            tick;
            total++;
            if ({locked, grant, reject} !== 5'b1_00_00) begin
                bad++;
                $display("FAIL lock_hold i=%0d got=%b exp=10000", i, {locked, grant, reject});
            end
        end
        tick;
        total++;
        if ({locked, grant} !== 3'b0) begin
            bad++;
            $display("FAIL lock_exit got=%b exp=000", {locked, grant});
        end
        tick;
        total++;
        if (grant !== 2'b10) begin
            bad++;
            $display("FAIL lock_b_grant got=%b exp=10", grant);
        end
        tick;
        total++;
        if ({done, en_left, en_right, waddr, dout} !== {2'b10, 1'b1, 1'b0, 2'd0, 4'h5}) begin
            bad++;
            $display("FAIL lock_b_write got=%b exp=%b", {done, en_left, en_right, waddr, dout},
                     {2'b10, 1'b1, 1'b0, 2'd0, 4'h5});
        end
        req = 2'b00;
        tick;
    endtask

    task automatic test_full_bank;
        do_reset;
        pass_data = 8'h0A;
        for (int k = 0; k < 4; k++) begin
            din = 8'(2 * k + 1);
            req = 2'b01;
            tick; tick;
            total++;
            if ({en_left, en_right, waddr, dout, done} !== {1'b1, 1'b0, 2'(k), 4'(2 * k + 1), 2'b01}) begin
                bad++;
                $display("FAIL full_write k=%0d got=%b exp=%b", k, {en_left, en_right, waddr, dout, done},
                         {1'b1, 1'b0, 2'(k), 4'(2 * k + 1), 2'b01});
            end
            req = 2'b00;
            tick;
        end
        total++;
        if ({left_count, left_full, right_full} !== {3'd4, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL full_flags lc=%0d lf=%b rf=%b exp 4 1 0", left_count, left_full, right_full);
        end
        din = 8'h09; req = 2'b01;
        tick; tick;
        total++;
        if ({reject, done, en_left, en_right} !== 6'b01_00_00) begin
            bad++;
            $display("FAIL full_refuse got=%b exp=010000", {reject, done, en_left, en_right});
        end
        req = 2'b00;
        tick;
        total++;
        if ({left_count, locked} !== {3'd4, 1'b0}) begin
            bad++;
            $display("FAIL full_hold lc=%0d locked=%b exp 4 0", left_count, locked);
        end
        // three more bad passwords are still required to lock
        pass_data = 8'h05;
        for (int k = 0; k < 3; k++) begin
            req = 2'b01;
            tick; tick;
            total++;
            if (reject !== 2'b01) begin
                bad++;
                $display("FAIL full_badpw k=%0d reject=%b exp=01", k, reject);
            end
            req = 2'b00;
            tick;
            total++;
            if (locked !== (k == 2)) begin
                bad++;
                $display("FAIL full_lockcount k=%0d locked=%b exp=%b", k, locked, (k == 2));
            end
        end
    endtask

    task automatic test_clear_in_write;
        do_reset;
        pass_data = 8'h0A;
        din = 8'h01; req = 2'b01;
        tick; tick;
        req = 2'b00;
        tick;
        for (int k = 0; k < 3; k++) begin
            din = 8'(2 * k); req = 2'b01;
            tick; tick;
            total++;
            if ({en_right, en_left, waddr} !== {1'b1, 1'b0, 2'(k)}) begin
                bad++;
                $display("FAIL clr_write k=%0d got=%b exp=%b", k, {en_right, en_left, waddr},
                         {1'b1, 1'b0, 2'(k)});
            end
            if (k == 2) begin
                total++;
                if ({left_count, right_count} !== {3'd1, 3'd2}) begin
                    bad++;
                    $display("FAIL clr_pre lc=%0d rc=%0d exp 1 2", left_count, right_count);
                end
                clear_banks = 1'b1;
            end
            req = 2'b00;
            tick;
            clear_banks = 1'b0;
        end
        total++;
        if ({left_count, right_count} !== {3'd0, 3'd1}) begin
            bad++;
            $display("FAIL clr_post lc=%0d rc=%0d exp 0 1", left_count, right_count);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        pass_data = 8'hAA; din = 8'h32; req = 2'b11;
        tick;
        total++;
        if (grant !== 2'b01) begin
            bad++;
            $display("FAIL rst_pre grant=%b exp=01", grant);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({grant, done, en_left, en_right} !== 6'b0) begin
            bad++;
            $display("FAIL rst_async got=%b exp=000000", {grant, done, en_left, en_right});
        end
        tick; tick;
        reset = 1'b0;
        tick;
        total++;
        if ({grant, done, en_left, en_right} !== 6'b01_00_00) begin
            bad++;
            $display("FAIL rst_regrant got=%b exp=010000", {grant, done, en_left, en_right});
        end
        tick;
        total++;
        if ({done, en_left, en_right, waddr} !== {2'b01, 1'b0, 1'b1, 2'd0}) begin
            bad++;
            $display("FAIL rst_write got=%b exp=0101 00", {done, en_left, en_right, waddr});
        end
        req = 2'b00;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_round_robin;
        test_lockout;
        test_full_bank;
        test_clear_in_write;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
